// File: rtl/simt_alu_pkg.sv
// Shared types and ALU function codes for the TinySIMT ALU sequencer.
package simt_alu_pkg;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} seq_state_t;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;

endpackage

// File: rtl/alu2.sv
// 32-bit ALU: f[3] selects multiply, f[2] inverts b (+1), f[1:0] picks and/or/sum/slt.
module alu2 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  f,
    output logic [31:0] y,
    output logic        zero,
    output logic        cout
);

    logic [31:0] bb;
    logic [32:0] sum;
    logic [31:0] prod;
    logic        lt;

    assign bb   = f[2] ? ~b : b;
    assign sum  = {1'b0, a} + {1'b0, bb} + {32'b0, f[2]};
    assign prod = a * b;
    // Signed compare: differing signs decide directly, otherwise the difference sign does.
    assign lt   = (a[31] != b[31]) ? a[31] : sum[31];

    always_comb begin
        y = '0;
        if (f[3]) begin
            y = prod;
        end else begin
            case (f[1:0])
                2'b00:   y = a & bb;
                2'b01:   y = a | bb;
                2'b10:   y = sum[31:0];
                default: y = {31'b0, lt};
            endcase
        end
    end

    assign zero = (y == 32'b0);
    assign cout = !f[3] && f[1] && sum[32];

endmodule

// File: rtl/lane_picker.sv
// Finds the lowest set mask bit at or above (incl=1) / strictly above (incl=0) a lane index.
module lane_picker #(
    parameter int LANES = 4,
    parameter int LW    = 2
) (
    input  logic [LANES-1:0] mask,
    input  logic [LW-1:0]    from,
    input  logic             incl,
    output logic             found,
    output logic [LW-1:0]    lane
);

    always_comb begin
        found = 1'b0;
        lane  = '0;
        // Scan downward so the lowest qualifying lane is the last one written.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i] && ((i > int'(from)) || (incl && (i == int'(from))))) begin
                found = 1'b1;
                lane  = LW'(i);
            end
        end
    end

endmodule

// File: rtl/simt_alu_sequencer.sv
// Time-shares one alu2 across the active lanes of a warp op and returns the gathered results.
module simt_alu_sequencer
    import simt_alu_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int MUL_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [3:0]            issue_f,
    input  logic [LANES-1:0]      issue_mask,
    input  logic [32*LANES-1:0]   issue_a,
    input  logic [32*LANES-1:0]   issue_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [32*LANES-1:0]   res_y,
    output logic [LANES-1:0]      res_zero,
    output logic [LANES-1:0]      res_cout,
    output logic                  busy
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(MUL_CYCLES - 1);

    seq_state_t                 state, state_n;
    logic [3:0]                 f_q;
    logic [LANES-1:0]           mask_q;
    logic [LANES-1:0][31:0]     a_q, b_q, y_q;
    logic [LANES-1:0]           zero_q, cout_q;
    logic [LW-1:0]              cur;
    logic [CW-1:0]              cyc;

    logic                       hs, last;
    logic [LANES-1:0]           pick_mask;
    logic [LW-1:0]              pick_from, pick_lane;
    logic                       pick_incl, pick_found;
    logic [31:0]                alu_y;
    logic                       alu_zero, alu_cout;

    assign hs   = issue_valid && (state == S_IDLE);
    assign last = !f_q[3] || (cyc == CYC_LAST);

    // One picker serves both the first-lane search at issue and the next-lane search in EXEC.
    always_comb begin
        pick_mask = mask_q;
        pick_from = cur;
        pick_incl = 1'b0;
        if (state == S_IDLE) begin
            pick_mask = issue_mask;
            pick_from = '0;
            pick_incl = 1'b1;
        end
    end

    lane_picker #(.LANES(LANES), .LW(LW)) u_pick (
        .mask  (pick_mask),
        .from  (pick_from),
        .incl  (pick_incl),
        .found (pick_found),
        .lane  (pick_lane)
    );

    alu2 u_alu (
        .a    (a_q[cur]),
        .b    (b_q[cur]),
        .f    (f_q),
        .y    (alu_y),
        .zero (alu_zero),
        .cout (alu_cout)
    );

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (hs) state_n = (issue_mask == '0) ? S_DONE : S_EXEC;
            S_EXEC:  if (last && !pick_found) state_n = S_DONE;
            S_DONE:  if (res_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            f_q    <= '0;
            mask_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            y_q    <= '0;
            zero_q <= '0;
            cout_q <= '0;
            cur    <= '0;
            cyc    <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (hs) begin
                        f_q    <= issue_f;
                        mask_q <= issue_mask;
                        a_q    <= issue_a;
                        b_q    <= issue_b;
                        y_q    <= '0;
                        zero_q <= '0;
                        cout_q <= '0;
                        cur    <= pick_lane;
                        cyc    <= '0;
                    end
                end
                S_EXEC: begin
                    if (last) begin
                        y_q[cur]    <= alu_y;
                        zero_q[cur] <= alu_zero;
                        cout_q[cur] <= alu_cout;
                        cyc         <= '0;
                        if (pick_found) cur <= pick_lane;
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign issue_ready = (state == S_IDLE);
    assign res_valid   = (state == S_DONE);
    assign busy        = (state != S_IDLE);
    assign res_y       = y_q;
    assign res_zero    = zero_q;
    assign res_cout    = cout_q;

endmodule
